// File: rtl/channel_pkt_joiner_if.sv
// Read-side bundle of the three-queue channel buffer plus the merged output stream.
// master: the side that owns the queues and the downstream sink; slave: the joiner.
interface channel_pkt_joiner_if #(
  parameter int unsigned META_W = 32
);
  logic [META_W-1:0] meta_data;
  logic              meta_valid;
  logic              meta_ready;

  logic [511:0]      pkt_data;
  logic              pkt_valid;
  logic              pkt_sop;
  logic              pkt_eop;
  logic [5:0]        pkt_empty;
  logic              pkt_ready;

  logic [511:0]      usr_data;
  logic              usr_valid;
  logic              usr_sop;
  logic              usr_eop;
  logic [5:0]        usr_empty;
  logic              usr_ready;

  logic [511:0]      out_data;
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic [5:0]        out_empty;
  logic              out_is_usr;
  logic [META_W-1:0] out_meta;
  logic              out_ready;

  modport master (
    output meta_data, meta_valid, input meta_ready,
    output pkt_data, pkt_valid, pkt_sop, pkt_eop, pkt_empty, input pkt_ready,
    output usr_data, usr_valid, usr_sop, usr_eop, usr_empty, input usr_ready,
    input out_data, out_valid, out_sop, out_eop, out_empty, out_is_usr, out_meta,
    output out_ready
  );

  modport slave (
    input meta_data, meta_valid, output meta_ready,
    input pkt_data, pkt_valid, pkt_sop, pkt_eop, pkt_empty, output pkt_ready,
    input usr_data, usr_valid, usr_sop, usr_eop, usr_empty, output usr_ready,
    output out_data, out_valid, out_sop, out_eop, out_empty, out_is_usr, out_meta,
    input out_ready
  );
endinterface

// File: rtl/channel_pkt_joiner.sv
// Joins the meta/pkt/usr queues of a channel buffer into one merged packet stream.
// Per packet: pop one metadata entry, forward the pkt segment, then (HAS_USR) the usr segment.
// Optional CHANNEL_JOIN_STATS_EN adds wrap-around packet/beat/stall counters.
module channel_pkt_joiner #(
  parameter bit          HAS_USR   = 1'b1,
  parameter int unsigned ERR_CNT_W = 16,
  parameter int unsigned META_W    = 32   // must match the interface META_W
) (
  input  logic                 clk,
  input  logic                 rst,
  channel_pkt_joiner_if.slave  chan,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef CHANNEL_JOIN_STATS_EN
  ,
  output logic [31:0]          stat_pkts,
  output logic [31:0]          stat_beats,
  output logic [31:0]          stat_stalls
`endif
);

  typedef enum logic [1:0] {StIdle, StPkt, StUsr} state_e;

  state_e state_q, state_d;
  logic   first_q, first_d;   // next fire is the first beat of a segment

  logic              out_valid_q, out_sop_q, out_eop_q, out_is_usr_q;
  logic [511:0]      out_data_q;
  logic [5:0]        out_empty_q;
  logic [META_W-1:0] out_meta_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic         adv;
  logic         meta_rdy, pkt_rdy, usr_rdy;
  logic         ld, ld_sop, ld_eop, ld_is_usr, err_evt;
  logic [511:0] ld_data;
  logic [5:0]   ld_empty;

  assign adv = chan.out_ready | ~out_valid_q;

  // Next-state, queue pops and the beat to load into the output register
  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    meta_rdy  = 1'b0;
    pkt_rdy   = 1'b0;
    usr_rdy   = 1'b0;
    ld        = 1'b0;
    ld_data   = chan.pkt_data;
    ld_sop    = 1'b0;
    ld_eop    = 1'b0;
    ld_empty  = 6'd0;
    ld_is_usr = 1'b0;
    err_evt   = !HAS_USR && chan.usr_valid;
    case (state_q)
      StIdle: begin
        meta_rdy = adv & chan.meta_valid;
        if (meta_rdy) begin
          state_d = StPkt;
          first_d = 1'b1;
        end
      end
      StPkt: begin
        pkt_rdy = adv;
        if (adv && chan.pkt_valid) begin
          ld      = 1'b1;
          ld_data = chan.pkt_data;
          // sop is forced on the first beat and dropped on any later one
          ld_sop  = first_q;
          if (first_q != chan.pkt_sop) err_evt = 1'b1;
          if (!HAS_USR) begin
            ld_eop   = chan.pkt_eop;
            ld_empty = chan.pkt_empty;
          end
          first_d = 1'b0;
          if (chan.pkt_eop) begin
            state_d = HAS_USR ? StUsr : StIdle;
            first_d = 1'b1;
          end
        end
      end
      StUsr: begin
        usr_rdy = adv;
        if (adv && chan.usr_valid) begin
          ld        = 1'b1;
          ld_data   = chan.usr_data;
          ld_is_usr = 1'b1;
          ld_eop    = chan.usr_eop;
          ld_empty  = chan.usr_empty;
          if (first_q != chan.usr_sop) err_evt = 1'b1;
          first_d = 1'b0;
          if (chan.usr_eop) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // no pops while the whole channel is being reset
    if (rst) begin
      meta_rdy = 1'b0;
      pkt_rdy  = 1'b0;
      usr_rdy  = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  // Output register, held metadata and saturating error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_is_usr_q <= 1'b0;
      out_data_q   <= '0;
      out_empty_q  <= '0;
      out_meta_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      if (ld) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= ld_data;
        out_sop_q    <= ld_sop;
        out_eop_q    <= ld_eop;
        out_empty_q  <= ld_empty;
        out_is_usr_q <= ld_is_usr;
      end else if (chan.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (meta_rdy) out_meta_q <= chan.meta_data;
      if (err_evt && (err_cnt_q != {ERR_CNT_W{1'b1}})) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign chan.meta_ready = meta_rdy;
  assign chan.pkt_ready  = pkt_rdy;
  assign chan.usr_ready  = HAS_USR ? usr_rdy : 1'b0;
  assign chan.out_valid  = out_valid_q;
  assign chan.out_data   = out_data_q;
  assign chan.out_sop    = out_sop_q;
  assign chan.out_eop    = out_eop_q;
  assign chan.out_empty  = out_empty_q;
  assign chan.out_is_usr = out_is_usr_q;
  assign chan.out_meta   = out_meta_q;
  assign err_cnt         = err_cnt_q;

`ifdef CHANNEL_JOIN_STATS_EN
  logic [31:0] stat_pkts_q, stat_beats_q, stat_stalls_q;

  // Wrap-around traffic statistics on the output side
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts_q   <= '0;
      stat_beats_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (out_valid_q && chan.out_ready) stat_beats_q <= stat_beats_q + 32'd1;
      if (out_valid_q && chan.out_ready && out_eop_q) stat_pkts_q <= stat_pkts_q + 32'd1;
      if (out_valid_q && !chan.out_ready) stat_stalls_q <= stat_stalls_q + 32'd1;
    end
  end

  assign stat_pkts   = stat_pkts_q;
  assign stat_beats  = stat_beats_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule
